// File: rtl/axis_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : axis_rx_fifo                                                     |
// | Brief   : AXI4-stream receive buffer, DEPTH-1 entry RAM + output register, |
// |           fully registered on both sides. AXIS_RX_FIFO_STATS_EN adds       |
// |           beat and stall counters.                                         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module axis_rx_fifo #(
    parameter int DATA_BITS = 64,  // matches AXI_DATA_BITS of the shared types
    parameter int DEPTH     = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [DATA_BITS-1:0]     s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [DATA_BITS-1:0]     m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   fill
`ifdef AXIS_RX_FIFO_STATS_EN
    ,
    output logic [31:0]              stat_beats,
    output logic [31:0]              stat_stalls
`endif
);

    localparam int c_ptr_bits  = $clog2(DEPTH);
    localparam int c_fill_bits = $clog2(DEPTH) + 1;
    localparam logic [c_ptr_bits-1:0]  c_ptr_last = c_ptr_bits'(DEPTH - 2);
    localparam logic [c_fill_bits-1:0] c_full     = c_fill_bits'(DEPTH);

    logic [DATA_BITS-1:0]   r_ram [0:DEPTH-2];
    logic [c_ptr_bits-1:0]  r_wr_ptr;
    logic [c_ptr_bits-1:0]  r_rd_ptr;
    logic [c_fill_bits-1:0] r_fill;
    logic                   r_out_valid;
    logic [DATA_BITS-1:0]   r_out_data;
    logic                   r_s_ready;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_load;
    logic                   w_ram_empty;
    logic                   w_ram_rd;
    logic                   w_ram_wr;
    logic [c_fill_bits-1:0] w_fill_next;

    function automatic logic [c_ptr_bits-1:0] f_ptr_inc(input logic [c_ptr_bits-1:0] ptr);
        return (ptr == c_ptr_last) ? '0 : ptr + 1'b1;
    endfunction

    assign w_push      = s_tvalid && r_s_ready;
    assign w_pop       = r_out_valid && m_tready;
    assign w_load      = !r_out_valid || w_pop;
    // RAM occupancy is fill minus the output register's beat.
    assign w_ram_empty = (r_fill == c_fill_bits'(r_out_valid));
    assign w_ram_rd    = w_load && !w_ram_empty;
    // An incoming beat bypasses the RAM when it goes straight to the output register.
    assign w_ram_wr    = w_push && !(w_load && w_ram_empty);
    assign w_fill_next = r_fill + c_fill_bits'(w_push) - c_fill_bits'(w_pop);

    always_ff @(posedge aclk) begin
        if (w_ram_wr) begin
            r_ram[r_wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_s_ready   <= 1'b0;
        end else begin
            r_fill    <= w_fill_next;
            r_s_ready <= (w_fill_next != c_full);
            if (w_ram_wr) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_ram_rd) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            if (w_load) begin
                if (!w_ram_empty) begin
                    r_out_data  <= r_ram[r_rd_ptr];
                    r_out_valid <= 1'b1;
                end else if (w_push) begin
                    r_out_data  <= s_tdata;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign s_tready = r_s_ready;
    assign m_tdata  = r_out_data;
    assign m_tvalid = r_out_valid;
    assign fill     = r_fill;

`ifdef AXIS_RX_FIFO_STATS_EN
    logic [31:0] r_stat_beats;
    logic [31:0] r_stat_stalls;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_stat_beats  <= '0;
            r_stat_stalls <= '0;
        end else begin
            if (w_push) begin
                r_stat_beats <= r_stat_beats + 32'd1;
            end
            if (r_out_valid && !m_tready) begin
                r_stat_stalls <= r_stat_stalls + 32'd1;
            end
        end
    end

    assign stat_beats  = r_stat_beats;
    assign stat_stalls = r_stat_stalls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_axis_rx_fifo                                                  |
// | Brief   : Self-checking bench for axis_rx_fifo (DEPTH=16 and DEPTH=4),     |
// |           queue-based reference model with random stimulus.                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_axis_rx_fifo;

    localparam int c_dw = 16;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;

    logic [c_dw-1:0] s_tdata = '0;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic [c_dw-1:0] m_tdata;
    logic            m_tvalid;
    logic            m_tready = 1'b0;
    logic [4:0]      fill;

    logic [c_dw-1:0] s4_tdata = '0;
    logic            s4_tvalid = 1'b0;
    logic            s4_tready;
    logic [c_dw-1:0] m4_tdata;
    logic            m4_tvalid;
    logic            m4_tready = 1'b0;
    logic [2:0]      fill4;

`ifdef AXIS_RX_FIFO_STATS_EN
    logic [31:0]     stat_beats, stat_stalls, stat4_beats, stat4_stalls;
`endif

    always #5 aclk = ~aclk;

    axis_rx_fifo #(.DATA_BITS(c_dw), .DEPTH(16)) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .fill(fill)
`ifdef AXIS_RX_FIFO_STATS_EN
        , .stat_beats(stat_beats), .stat_stalls(stat_stalls)
`endif
    );

    axis_rx_fifo #(.DATA_BITS(c_dw), .DEPTH(4)) u_dut4 (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(s4_tdata), .s_tvalid(s4_tvalid), .s_tready(s4_tready),
        .m_tdata(m4_tdata), .m_tvalid(m4_tvalid), .m_tready(m4_tready),
        .fill(fill4)
`ifdef AXIS_RX_FIFO_STATS_EN
        , .stat_beats(stat4_beats), .stat_stalls(stat4_stalls)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: each buffer is just an ordered queue of held beats.
    logic [c_dw-1:0] q16[$];
    logic [c_dw-1:0] q4[$];
    logic            rdy16 = 1'b0;
    logic            rdy4  = 1'b0;
    int              beats_exp  = 0;
    int              stalls_exp = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step16(input logic v, input logic [c_dw-1:0] d, input logic r, output logic acc);
        logic pop;
        s_tvalid = v; s_tdata = d; m_tready = r;
        @(posedge aclk);
        acc = v && rdy16;
        pop = r && (q16.size() > 0);
        if (!r && q16.size() > 0) stalls_exp++;
        if (acc) beats_exp++;
        if (pop) void'(q16.pop_front());
        if (acc) q16.push_back(d);
        rdy16 = (q16.size() != 16);
        #1;
        check("valid16", m_tvalid, q16.size() > 0);
        if (q16.size() > 0) check("data16", m_tdata, q16[0]);
        check("fill16", fill, q16.size());
        check("ready16", s_tready, rdy16);
    endtask

    task automatic step4(input logic v, input logic [c_dw-1:0] d, input logic r,
                         output logic acc, output logic pop);
        s4_tvalid = v; s4_tdata = d; m4_tready = r;
        @(posedge aclk);
        acc = v && rdy4;
        pop = r && (q4.size() > 0);
        if (pop) void'(q4.pop_front());
        if (acc) q4.push_back(d);
        rdy4 = (q4.size() != 4);
        #1;
        check("valid4", m4_tvalid, q4.size() > 0);
        if (q4.size() > 0) check("data4", m4_tdata, q4[0]);
        check("fill4", fill4, q4.size());
        check("ready4", s4_tready, rdy4);
    endtask

    task automatic model_clear();
        q16.delete(); q4.delete();
        rdy16 = 1'b0; rdy4 = 1'b0;
        beats_exp = 0; stalls_exp = 0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        model_clear();
        #1;
        check("rst_valid", m_tvalid, 1'b0);
        check("rst_ready", s_tready, 1'b0);
        check("rst_fill", fill, 0);
        check("rst_data", m_tdata, 0);
        @(posedge aclk);
        #3 aresetn = 1'b1;
    endtask

    initial begin
        logic acc, pop;
        int   idx, recv, cyc;
        logic [c_dw-1:0] pend;

        do_reset();

        // Pass-through: one beat per cycle, fill never above 1.
        step16(1'b0, '0, 1'b1, acc);
        for (int i = 0; i < 100; i++) begin
            step16(1'b1, c_dw'(i), 1'b1, acc);
            if (i == 0) check("pt_first_valid", m_tvalid, 1'b1);
        end
        check("pt_fill_max", fill, 1);
        repeat (3) step16(1'b0, '0, 1'b1, acc);

        // Fill to full with downstream stalled; beats 16..19 held upstream.
        idx = 0;
        repeat (24) begin
            step16(1'b1, c_dw'(16'h100 + idx), 1'b0, acc);
            if (acc) idx++;
        end
        check("full_accepted", idx, 16);
        check("full_fill", fill, 16);
        check("full_ready", s_tready, 1'b0);
        // Simultaneous valid/ready at full: only the pop happens.
        step16(1'b1, c_dw'(16'h100 + idx), 1'b1, acc);
        check("full_simul_acc", acc, 1'b0);
        check("full_simul_fill", fill, 15);
        check("full_simul_ready", s_tready, 1'b1);
        while (idx < 20) begin
            step16(1'b1, c_dw'(16'h100 + idx), 1'b1, acc);
            if (acc) idx++;
        end
        repeat (20) step16(1'b0, '0, 1'b1, acc);
        check("drain_fill", fill, 0);

        // Reset asserted mid-cycle with 5 beats held.
        for (int i = 0; i < 5; i++) step16(1'b1, c_dw'(16'h50 + i), 1'b0, acc);
        check("mid_fill5", fill, 5);
        #2 aresetn = 1'b0;
        #1;
        check("mid_rst_valid", m_tvalid, 1'b0);
        check("mid_rst_ready", s_tready, 1'b0);
        check("mid_rst_fill", fill, 0);
        model_clear();
        @(posedge aclk);
        #3 aresetn = 1'b1;
        step16(1'b0, '0, 1'b0, acc);
        step16(1'b1, 16'h00A5, 1'b0, acc);
        check("mid_new_data", m_tdata, 16'h00A5);
        step16(1'b0, '0, 1'b1, acc);

        // Random valid/ready on the DEPTH=4 instance.
        do_reset();
        idx = 0; recv = 0; cyc = 0;
        pend = c_dw'($urandom);
        while (recv < 10000 && cyc < 60000) begin
            step4((idx < 10000) && ($urandom % 2 == 0), pend, ($urandom % 2 == 0), acc, pop);
            if (acc) begin
                idx++;
                pend = c_dw'($urandom);
            end
            if (pop) recv++;
            cyc++;
        end
        check("rand_received", recv, 10000);

`ifdef AXIS_RX_FIFO_STATS_EN
        do_reset();
        step16(1'b0, '0, 1'b1, acc);
        for (int i = 0; i < 37; i++) step16(1'b1, c_dw'(i), (i >= 10), acc);
        repeat (20) step16(1'b0, '0, 1'b1, acc);
        check("stat_beats_model", stat_beats, beats_exp);
        check("stat_stalls_model", stat_stalls, stalls_exp);
        check("stat_beats", stat_beats, 37);
        check("stat_stalls", stat_stalls, 9);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
